// File: rtl/bp_common_cfg_link_pkg.sv
// Shared constants and types for the processor-configuration link.
// Header beat: magic in the top byte, config id in the low bits.
package bp_common_cfg_link_pkg;

   localparam int unsigned cfg_magic_width_gp = 8;
   localparam logic [cfg_magic_width_gp-1:0] cfg_magic_gp = 8'hC5;
   localparam int unsigned cfg_hdr_id_lsb_gp  = 0;

   typedef enum logic [1:0] {
      e_cfg_err_none  = 2'd0,
      e_cfg_err_magic = 2'd1,
      e_cfg_err_csum  = 2'd2
   } bp_cfg_link_err_e;

   typedef enum logic [1:0] {
      e_idle    = 2'd0,
      e_payload = 2'd1,
      e_check   = 2'd2,
      e_error   = 2'd3
   } bp_cfg_link_state_e;

endpackage

// File: rtl/bp_proc_cfg_deserializer.sv
// Reassembles a header/payload/checksum beat stream into a proc-param record
// and commits it atomically to the outputs only when the checksum matches.
module bp_proc_cfg_deserializer
   import bp_common_cfg_link_pkg::*;
#(
   parameter int unsigned cfg_width_p   = 96,
   parameter int unsigned chunk_width_p = 32,
   parameter int unsigned lg_max_cfgs_p = 7
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [chunk_width_p-1:0] data_i,
   input  logic                     v_i,
   output logic                     ready_o,
   input  logic                     clear_i,
   output logic [cfg_width_p-1:0]   cfg_o,
   output logic [lg_max_cfgs_p-1:0] cfg_id_o,
   output logic                     cfg_v_o,
   output logic                     commit_o,
   output logic                     busy_o,
   output logic [1:0]               err_o
);

   localparam int unsigned num_beats_lp    = (cfg_width_p + chunk_width_p - 1) / chunk_width_p;
   localparam int unsigned shadow_width_lp = num_beats_lp * chunk_width_p;
   localparam int unsigned cnt_width_lp    = (num_beats_lp > 1) ? $clog2(num_beats_lp) : 1;

   bp_cfg_link_state_e           r_state, w_state_n;
   bp_cfg_link_err_e             r_err, w_err_n;
   logic [cnt_width_lp-1:0]      r_cnt, w_cnt_n;
   logic [chunk_width_p-1:0]     r_acc, w_acc_n;
   logic [shadow_width_lp-1:0]   r_shadow, w_shadow_n;
   logic [lg_max_cfgs_p-1:0]     r_id, w_id_n;
   logic [cfg_width_p-1:0]       r_cfg, w_cfg_n;
   logic [lg_max_cfgs_p-1:0]     r_cfg_id, w_cfg_id_n;
   logic                         r_cfg_v, w_cfg_v_n;
   logic                         r_commit, w_commit_n;
   logic                         r_busy, w_busy_n;
   logic                         r_ready, w_ready_n;

   logic w_accept, w_magic_ok, w_last;

   assign w_accept   = v_i & r_ready;
   assign w_magic_ok = (data_i[chunk_width_p-1 -: cfg_magic_width_gp] == cfg_magic_gp);
   assign w_last     = (r_cnt == cnt_width_lp'(num_beats_lp - 1));

   // Next-state and next-output logic; ready/busy are registered from the next state.
   always_comb begin
      w_state_n  = r_state;
      w_err_n    = r_err;
      w_cnt_n    = r_cnt;
      w_acc_n    = r_acc;
      w_shadow_n = r_shadow;
      w_id_n     = r_id;
      w_cfg_n    = r_cfg;
      w_cfg_id_n = r_cfg_id;
      w_cfg_v_n  = r_cfg_v;
      w_commit_n = 1'b0;

      case (r_state)
         e_idle: begin
            if (w_accept) begin
               if (w_magic_ok) begin
                  w_id_n    = data_i[cfg_hdr_id_lsb_gp +: lg_max_cfgs_p];
                  w_cnt_n   = '0;
                  w_acc_n   = '0;
                  w_state_n = e_payload;
               end else begin
                  w_err_n   = e_cfg_err_magic;
                  w_state_n = e_error;
               end
            end
         end
         e_payload: begin
            if (w_accept) begin
               for (int unsigned k = 0; k < num_beats_lp; k++) begin
                  if (r_cnt == cnt_width_lp'(k)) begin
                     w_shadow_n[k*chunk_width_p +: chunk_width_p] = data_i;
                  end
               end
               w_acc_n = r_acc ^ data_i;
               w_cnt_n = r_cnt + cnt_width_lp'(1);
               if (w_last) begin
                  w_state_n = e_check;
               end
            end
         end
         e_check: begin
            if (w_accept) begin
               if (data_i == r_acc) begin
                  w_cfg_n    = r_shadow[cfg_width_p-1:0];
                  w_cfg_id_n = r_id;
                  w_cfg_v_n  = 1'b1;
                  w_commit_n = 1'b1;
                  w_state_n  = e_idle;
               end else begin
                  w_err_n   = e_cfg_err_csum;
                  w_state_n = e_error;
               end
            end
         end
         e_error: begin
            if (clear_i) begin
               w_err_n   = e_cfg_err_none;
               w_state_n = e_idle;
            end
         end
         default: begin
            w_state_n = e_idle;
         end
      endcase

      w_ready_n = (w_state_n != e_error);
      w_busy_n  = (w_state_n == e_payload) || (w_state_n == e_check);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state  <= e_idle;
         r_err    <= e_cfg_err_none;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_shadow <= '0;
         r_id     <= '0;
         r_cfg    <= '0;
         r_cfg_id <= '0;
         r_cfg_v  <= 1'b0;
         r_commit <= 1'b0;
         r_busy   <= 1'b0;
         r_ready  <= 1'b1;
      end else begin
         r_state  <= w_state_n;
         r_err    <= w_err_n;
         r_cnt    <= w_cnt_n;
         r_acc    <= w_acc_n;
         r_shadow <= w_shadow_n;
         r_id     <= w_id_n;
         r_cfg    <= w_cfg_n;
         r_cfg_id <= w_cfg_id_n;
         r_cfg_v  <= w_cfg_v_n;
         r_commit <= w_commit_n;
         r_busy   <= w_busy_n;
         r_ready  <= w_ready_n;
      end
   end

   assign ready_o  = r_ready;
   assign cfg_o    = r_cfg;
   assign cfg_id_o = r_cfg_id;
   assign cfg_v_o  = r_cfg_v;
   assign commit_o = r_commit;
   assign busy_o   = r_busy;
   assign err_o    = r_err;

endmodule
